ipf_if_ctrl: RTL and testbench

Fetch-stage sequencer that drives the IPF/IF pipeline registers. It runs the instruction-memory request handshake and generates IPF_IF stall/flush and the PC-advance enable. It also tracks delay-slot status and discards stale responses left over from a flush or redirect. It sits between the PC unit, the I-side bus/cache interface, the ITLB result and the ID-stage hazard/exception logic.

---
 rtl/ipf_if_ctrl.sv | 150 +++++++++++++++
 tb/tb_ipf_if_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_if_ctrl.sv
// Fetch-stage sequencer: instruction-memory request handshake, IPF_IF stall/flush,
// PC-advance enable, delay-slot tracking and discard of stale responses after a redirect.
module ipf_if_ctrl #(
    parameter int MAX_DISCARD = 3,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             exc_flush,
    input  logic             br_redirect,
    input  logic             br_in_id,
    input  logic [1:0]       pc_low,
    input  logic             inst_miss,
    input  logic             inst_valid,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    output logic             inst_req,
    output logic             pc_en,
    output logic             ipf_if_stall,
    output logic             ipf_if_flush,
    output logic             is_delayslot,
    output logic             fetch_exc,
    output logic [CNT_W-1:0] discard_cnt
);

    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DISCARD);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ds_q, ds_d;
    logic             exc_q, exc_d;

    logic fetchFault;
    logic flush;
    logic retire;
    logic newStale;
    logic advance;
    logic slotExc;

    assign fetchFault  = (pc_low != 2'b00) || inst_miss || !inst_valid;
    assign flush       = exc_flush || br_redirect;
    assign discard_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            cnt_q   <= '0;
            ds_q    <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ds_q    <= ds_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ds_d         = ds_q;
        exc_d        = exc_q;
        inst_req     = 1'b0;
        pc_en        = 1'b0;
        ipf_if_stall = 1'b1;
        ipf_if_flush = 1'b0;
        is_delayslot = 1'b0;
        fetch_exc    = 1'b0;
        advance      = 1'b0;
        slotExc      = 1'b0;
        newStale     = 1'b0;
        retire       = inst_data_ok && (cnt_q != '0);

        case (state_q)
            S_REQ: begin
                inst_req = !fetchFault && (cnt_q < MAX_CNT);
                if (flush) begin
                    newStale = inst_addr_ok && inst_req;
                end else if (fetchFault) begin
                    if (!id_stall) begin
                        advance = 1'b1;
                        slotExc = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                        exc_d   = 1'b1;
                    end
                end else if (inst_addr_ok && inst_req) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A stale response retiring under a flush is replaced by the live one going stale
                if (flush) begin
                    newStale = !inst_data_ok || (cnt_q != '0);
                end else if (inst_data_ok && (cnt_q == '0)) begin
                    if (!id_stall) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!flush && !id_stall) begin
                    advance = 1'b1;
                    slotExc = exc_q;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (flush) begin
            pc_en        = 1'b1;
            ipf_if_flush = 1'b1;
            state_d      = S_REQ;
            ds_d         = 1'b0;
            exc_d        = 1'b0;
        end else if (advance) begin
            pc_en        = 1'b1;
            ipf_if_stall = 1'b0;
            is_delayslot = ds_q || br_in_id;
            fetch_exc    = slotExc;
            state_d      = S_REQ;
            ds_d         = 1'b0;
            exc_d        = 1'b0;
        end else if (br_in_id) begin
            ds_d = 1'b1;
        end

        cnt_d = cnt_q;
        if (newStale && !retire) begin
            cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
        end else if (retire && !newStale) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (rst) begin
            pc_en        = 1'b0;
            ipf_if_stall = 1'b0;
            ipf_if_flush = 1'b0;
            is_delayslot = 1'b0;
            fetch_exc    = 1'b0;
        end
    end

endmodule

// File: tb/tb_ipf_if_ctrl.sv
// Directed bench for ipf_if_ctrl: a request-queue model checked every cycle,
// plus hand-computed expectations at the interesting points of each sequence.
module tb_ipf_if_ctrl;

    localparam int MAX_DISCARD = 3;
    localparam int CNT_W       = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_stall, exc_flush, br_redirect, br_in_id;
    logic [1:0]       pc_low;
    logic             inst_miss, inst_valid, inst_addr_ok, inst_data_ok;
    logic             inst_req, pc_en, ipf_if_stall, ipf_if_flush, is_delayslot, fetch_exc;
    logic [CNT_W-1:0] discard_cnt;

    int checks   = 0;
    int failures = 0;

    ipf_if_ctrl #(.MAX_DISCARD(MAX_DISCARD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_stall(id_stall), .exc_flush(exc_flush), .br_redirect(br_redirect),
        .br_in_id(br_in_id), .pc_low(pc_low), .inst_miss(inst_miss),
        .inst_valid(inst_valid), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_req(inst_req), .pc_en(pc_en), .ipf_if_stall(ipf_if_stall),
        .ipf_if_flush(ipf_if_flush), .is_delayslot(is_delayslot),
        .fetch_exc(fetch_exc), .discard_cnt(discard_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic idSt, input logic exc, input logic br,
                                 input logic bid, input logic [1:0] pcl, input logic miss,
                                 input logic vld, input logic aok, input logic dok);
        @(posedge clk);
        #1;
        id_stall     = idSt;
        exc_flush    = exc;
        br_redirect  = br;
        br_in_id     = bid;
        pc_low       = pcl;
        inst_miss    = miss;
        inst_valid   = vld;
        inst_addr_ok = aok;
        inst_data_ok = dok;
        #1;
    endtask

    // Model: FIFO of outstanding requests (1 = live, 0 = stale) plus a held slot.
    bit q[$];
    bit held, heldExc, mDs;
    int staleN;
    bit liveOut, inReq, fault, expReq, arrived, present, presentExc;
    bit expPc, expSt, expFl, expDs, expExc;

    always @(negedge clk) begin
        fault = (pc_low != 2'b00) || inst_miss || !inst_valid;
        if (rst) begin
            q.delete();
            held = 0; heldExc = 0; mDs = 0;
            checkOutput("rstReq", inst_req, !fault);
            checkOutput("rstPc", pc_en, 0);
            checkOutput("rstStall", ipf_if_stall, 0);
            checkOutput("rstFlush", ipf_if_flush, 0);
            checkOutput("rstDs", is_delayslot, 0);
            checkOutput("rstExc", fetch_exc, 0);
            checkOutput("rstCnt", discard_cnt, 0);
        end else begin
            staleN  = 0;
            liveOut = 0;
            foreach (q[i]) begin
                if (q[i]) liveOut = 1;
                else staleN++;
            end
            inReq  = !liveOut && !held;
            expReq = inReq && !fault && (staleN < MAX_DISCARD);
            arrived = 0;
            if (inst_data_ok && q.size() > 0) begin
                arrived = q[0];
                q.pop_front();
            end
            present    = held || arrived || (inReq && fault);
            presentExc = held ? heldExc : (inReq && fault && !arrived);
            expPc = 0; expSt = 1; expFl = 0; expDs = 0; expExc = 0;
            if (exc_flush || br_redirect) begin
                expPc = 1;
                expFl = 1;
                foreach (q[i]) q[i] = 0;
                if (expReq && inst_addr_ok) q.push_back(0);
                if (q.size() > MAX_DISCARD) q.pop_back();
                held = 0;
                mDs  = 0;
            end else if (present && !id_stall) begin
                expPc  = 1;
                expSt  = 0;
                expDs  = mDs || br_in_id;
                expExc = presentExc;
                held   = 0;
                mDs    = 0;
            end else begin
                if (present) begin
                    held    = 1;
                    heldExc = presentExc;
                end
                if (br_in_id) mDs = 1;
                if (expReq && inst_addr_ok) q.push_back(1);
            end
            checkOutput("modelReq", inst_req, expReq);
            checkOutput("modelPc", pc_en, expPc);
            checkOutput("modelStall", ipf_if_stall, expSt);
            checkOutput("modelFlush", ipf_if_flush, expFl);
            checkOutput("modelDs", is_delayslot, expDs);
            checkOutput("modelExc", fetch_exc, expExc);
            checkOutput("modelCnt", discard_cnt, staleN);
        end
    end

    initial begin
        rst = 1'b1;
        id_stall = 0; exc_flush = 0; br_redirect = 0; br_in_id = 0;
        pc_low = 2'b00; inst_miss = 0; inst_valid = 1; inst_addr_ok = 0; inst_data_ok = 0;
        #2;
        checkOutput("resetStall", ipf_if_stall, 0);
        checkOutput("resetCnt", discard_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back fetch: one advance every two cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
            checkOutput("b2bReq", inst_req, 1);
            checkOutput("b2bNoPc", pc_en, 0);
            applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
            checkOutput("b2bPc", pc_en, 1);
            checkOutput("b2bStall", ipf_if_stall, 0);
            checkOutput("b2bFlush", ipf_if_flush, 0);
        end

        // ID stall holds the fetched instruction for four cycles
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(1, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("holdStallT", ipf_if_stall, 1);
        checkOutput("holdPcT", pc_en, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 2'b00, 0, 1, 0, 0);
            checkOutput("holdStall", ipf_if_stall, 1);
            checkOutput("holdNoReq", inst_req, 0);
        end
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("holdRelease", pc_en, 1);

        // Branch redirect while a request is outstanding
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("brFlush", ipf_if_flush, 1);
        checkOutput("brPc", pc_en, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("staleCnt1", discard_cnt, 1);
        checkOutput("staleNoPc", pc_en, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        checkOutput("staleCnt0", discard_cnt, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("afterStalePc", pc_en, 1);

        // Flush coincident with the response
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("coFlush", ipf_if_flush, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("coCnt", discard_cnt, 0);

        // Three flushes saturate the discard counter and block requests
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
            applyStimulus(0, 0, 1, 0, 2'b00, 0, 1, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("satCnt", discard_cnt, 3);
        checkOutput("satNoReq", inst_req, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("satDropPc", pc_en, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("satCnt2", discard_cnt, 2);
        checkOutput("satReq", inst_req, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("drainCnt", discard_cnt, 0);

        // Fetch faults advance without a memory access
        applyStimulus(0, 0, 0, 0, 2'b10, 0, 1, 0, 0);
        checkOutput("faultNoReq", inst_req, 0);
        checkOutput("faultPc", pc_en, 1);
        checkOutput("faultExc", fetch_exc, 1);
        applyStimulus(1, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        checkOutput("missHeld", pc_en, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("missPc", pc_en, 1);
        checkOutput("missExc", fetch_exc, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        checkOutput("invalidExc", fetch_exc, 1);

        // Delay slot marks exactly the next advance
        applyStimulus(0, 0, 0, 1, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("dsSet", is_delayslot, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("dsClear", is_delayslot, 0);

        // An exception between branch and advance cancels the delay slot
        applyStimulus(0, 0, 0, 1, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("dsStaleNoPc", pc_en, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("dsFlushedPc", pc_en, 1);
        checkOutput("dsFlushed", is_delayslot, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 2'b00, 0, 1, 0, 1);
        checkOutput("dsCoincident", is_delayslot, 1);

        // Reset in the middle of a discard
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 0, 2'b00, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        checkOutput("preRstCnt", discard_cnt, 1);
        rst = 1'b1;
        #1;
        checkOutput("midRstCnt", discard_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        checkOutput("postRstPc", pc_en, 1);
        applyStimulus(0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
